// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

  localparam int WORD_W      = 32;
  localparam int STRB_W      = WORD_W / 8;
  localparam int MAX_LATENCY = 15;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_sram_array.sv
// Word-addressed storage with a byte-strobed synchronous write port and a registered read port.
module dmem_sram_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // No reset on purpose: contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < STRB_W; i++) begin
          if (wstrb[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with programmable access latency (1..15 cycles).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH);

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              cap_we_reg;
  logic [31:0]       cap_addr_reg;
  logic [WORD_W-1:0] cap_wdata_reg;
  logic [STRB_W-1:0] cap_wstrb_reg;
  logic              rsp_valid_reg;
  logic              rsp_err_reg;
  logic              load_ok_reg;
  logic [WORD_W-1:0] sram_rdata;

  logic fault;
  logic access;
  logic mem_en;

  assign fault  = (cap_addr_reg[1:0] != 2'b00) || (cap_addr_reg[31:2] >= 30'(DEPTH));
  assign access = (state_reg == BUSY) && (cnt_reg == '0);
  assign mem_en = access && !fault;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cap_we_reg    <= 1'b0;
      cap_addr_reg  <= '0;
      cap_wdata_reg <= '0;
      cap_wstrb_reg <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      load_ok_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            cap_we_reg    <= req_we;
            cap_addr_reg  <= req_addr;
            cap_wdata_reg <= req_wdata;
            cap_wstrb_reg <= req_wstrb;
            cnt_reg       <= CNT_W'(LATENCY - 1);
            state_reg     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_reg == '0) begin
            state_reg     <= RESP;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= fault;
            load_ok_reg   <= !fault && !cap_we_reg;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            load_ok_reg   <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  dmem_sram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .en    (mem_en),
    .we    (cap_we_reg),
    .addr  (cap_addr_reg[AW+1:2]),
    .wdata (cap_wdata_reg),
    .wstrb (cap_wstrb_reg),
    .rdata (sram_rdata)
  );

  // The array output has no reset, so it is gated by a registered qualifier
  // that is only set for a successful load and clears on reset/handshake.
  assign rsp_rdata = load_ok_reg ? sram_rdata : '0;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign req_ready = rst && (state_reg == IDLE);

endmodule
